gf_mult_pipe: RTL

//  Pipelined, parametrised GF(2^8) multiplier engine (AES poly x^8+x^4+x^3+x+1, 0x11B).

---
 rtl/aes_gf_pkg.sv | 36 +++
 rtl/gf_mult_pipe_if.sv | 27 ++
 rtl/gf_xtime_chain.sv | 21 ++
 rtl/gf_mult_pipe.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/aes_gf_pkg.sv
// Shared GF(2^8) definitions for the AES field (x^8+x^4+x^3+x+1): reduction constant,
// mode encoding, xtime and a reference multiply.
package aes_gf_pkg;

  localparam logic [7:0] AES_POLY = 8'h1B;

  typedef enum logic [1:0] {
    GF_MODE_SCALAR = 2'b00,
    GF_MODE_MIX    = 2'b01,
    GF_MODE_INVMIX = 2'b10,
    GF_MODE_PASS   = 2'b11
  } gf_mode_e;

  // xt[i] = x^i * a, i = 0..7
  typedef logic [7:0][7:0] gf_xt_t;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return a[7] ? ({a[6:0], 1'b0} ^ AES_POLY) : {a[6:0], 1'b0};
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    logic [7:0] y;
    p = '0;
    x = a;
    y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = xtime(x);
      y = y >> 1;
    end
    return p;
  endfunction

endpackage

// File: rtl/gf_mult_pipe_if.sv
// Beat-level handshake bundle of the GF multiplier engine. The parity lane vector exists
// only when GF_MULT_PARITY_EN is defined.
interface gf_mult_pipe_if #(parameter int LANES = 4);

  logic                 in_valid;
  logic                 in_ready;
  logic [8*LANES-1:0]   in_data;
  logic [7:0]           in_coef;
  logic [1:0]           in_mode;
  logic                 out_valid;
  logic                 out_ready;
  logic [8*LANES-1:0]   out_data;
`ifdef GF_MULT_PARITY_EN
  logic [LANES-1:0]     out_parity;

  modport master (output in_valid, in_data, in_coef, in_mode, out_ready,
                  input  in_ready, out_valid, out_data, out_parity);
  modport slave  (input  in_valid, in_data, in_coef, in_mode, out_ready,
                  output in_ready, out_valid, out_data, out_parity);
`else
  modport master (output in_valid, in_data, in_coef, in_mode, out_ready,
                  input  in_ready, out_valid, out_data);
  modport slave  (input  in_valid, in_data, in_coef, in_mode, out_ready,
                  output in_ready, out_valid, out_data);
`endif

endinterface

// File: rtl/gf_xtime_chain.sv
// Combinational chain producing x^0..x^7 multiples of one byte in GF(2^8).
module gf_xtime_chain
  import aes_gf_pkg::*;
(
  input  logic [7:0] i_byte,
  output gf_xt_t     o_xt
);

  always_comb begin
    o_xt    = '0;
    o_xt[0] = i_byte;
    o_xt[1] = xtime(o_xt[0]);
    o_xt[2] = xtime(o_xt[1]);
    o_xt[3] = xtime(o_xt[2]);
    o_xt[4] = xtime(o_xt[3]);
    o_xt[5] = xtime(o_xt[4]);
    o_xt[6] = xtime(o_xt[5]);
    o_xt[7] = xtime(o_xt[6]);
  end

endmodule

// File: rtl/gf_mult_pipe.sv
// Pipelined runtime-coefficient GF(2^8) engine: SCALAR, MixColumns, InvMixColumns, PASS.
// Optional GF_MULT_PARITY_EN adds a registered per-lane parity output.
module gf_mult_pipe
  import aes_gf_pkg::*;
#(
  parameter int LANES  = 4,
  parameter int STAGES = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  gf_mult_pipe_if.slave  bus
);

  if (LANES < 4 || (LANES % 4) != 0) begin : g_bad_lanes
    $error("gf_mult_pipe: LANES must be a positive multiple of 4");
  end
  if (STAGES != 1 && STAGES != 2) begin : g_bad_stages
    $error("gf_mult_pipe: STAGES must be 1 or 2");
  end

  function automatic logic [7:0] gf_scalar(input gf_xt_t xt, input logic [7:0] c);
    return ({8{c[0]}} & xt[0]) ^ ({8{c[1]}} & xt[1]) ^
           ({8{c[2]}} & xt[2]) ^ ({8{c[3]}} & xt[3]) ^
           ({8{c[4]}} & xt[4]) ^ ({8{c[5]}} & xt[5]) ^
           ({8{c[6]}} & xt[6]) ^ ({8{c[7]}} & xt[7]);
  endfunction

  gf_xt_t [LANES-1:0]    w_xt_p0;
  gf_xt_t [LANES-1:0]    w_xt_src;
  logic   [7:0]          w_coef_src;
  gf_mode_e              w_mode_src;
  logic                  w_vld_src;
  logic                  w_rdy_out;
  logic [LANES-1:0][7:0] w_comb;
  logic [LANES-1:0]      w_par;

  logic                  r_vld_out;
  logic [8*LANES-1:0]    r_data_out;

  for (genvar gl = 0; gl < LANES; gl++) begin : g_chain
    gf_xtime_chain u_chain (
      .i_byte (bus.in_data[8*gl +: 8]),
      .o_xt   (w_xt_p0[gl])
    );
  end

  // A stage frees itself when empty or when the stage after it moves; bubbles collapse.
  assign w_rdy_out = !r_vld_out || bus.out_ready;

  if (STAGES == 2) begin : g_two
    // ---- stage 1: xtime multiples with the beat's coef and mode ----
    gf_xt_t [LANES-1:0] r_xt_p1;
    logic   [7:0]       r_coef_p1;
    gf_mode_e           r_mode_p1;
    logic               r_vld_p1;

    assign bus.in_ready = !r_vld_p1 || w_rdy_out;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_vld_p1  <= 1'b0;
        r_xt_p1   <= '0;
        r_coef_p1 <= '0;
        r_mode_p1 <= GF_MODE_SCALAR;
      end else if (bus.in_ready) begin
        r_vld_p1 <= bus.in_valid;
        if (bus.in_valid) begin
          r_xt_p1   <= w_xt_p0;
          r_coef_p1 <= bus.in_coef;
          r_mode_p1 <= gf_mode_e'(bus.in_mode);
        end
      end
    end

    assign w_xt_src   = r_xt_p1;
    assign w_coef_src = r_coef_p1;
    assign w_mode_src = r_mode_p1;
    assign w_vld_src  = r_vld_p1;
  end else begin : g_one
    assign bus.in_ready = w_rdy_out;
    assign w_xt_src     = w_xt_p0;
    assign w_coef_src   = bus.in_coef;
    assign w_mode_src   = gf_mode_e'(bus.in_mode);
    assign w_vld_src    = bus.in_valid;
  end

  // ---- output stage: XOR-combine per mode into the output register ----
  for (genvar gl = 0; gl < LANES; gl++) begin : g_comb
    localparam int BASE = (gl / 4) * 4;
    localparam int ROW  = gl % 4;
    localparam int I1   = BASE + (ROW + 1) % 4;
    localparam int I2   = BASE + (ROW + 2) % 4;
    localparam int I3   = BASE + (ROW + 3) % 4;

    logic [7:0] w_lane;

    always_comb begin
      w_lane = w_xt_src[gl][0];
      case (w_mode_src)
        GF_MODE_SCALAR: w_lane = gf_scalar(w_xt_src[gl], w_coef_src);
        GF_MODE_MIX:    w_lane = gf_scalar(w_xt_src[gl], 8'h02) ^ gf_scalar(w_xt_src[I1], 8'h03) ^
                                 w_xt_src[I2][0] ^ w_xt_src[I3][0];
        GF_MODE_INVMIX: w_lane = gf_scalar(w_xt_src[gl], 8'h0E) ^ gf_scalar(w_xt_src[I1], 8'h0B) ^
                                 gf_scalar(w_xt_src[I2], 8'h0D) ^ gf_scalar(w_xt_src[I3], 8'h09);
        default:        w_lane = w_xt_src[gl][0];
      endcase
    end

    assign w_comb[gl] = w_lane;
    assign w_par[gl]  = ^w_lane;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_out  <= 1'b0;
      r_data_out <= '0;
    end else if (w_rdy_out) begin
      r_vld_out <= w_vld_src;
      if (w_vld_src) r_data_out <= w_comb;
    end
  end

  assign bus.out_valid = r_vld_out;
  assign bus.out_data  = r_data_out;

`ifdef GF_MULT_PARITY_EN
  logic [LANES-1:0] r_par_out;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_par_out <= '0;
    end else if (w_rdy_out && w_vld_src) begin
      r_par_out <= w_par;
    end
  end

  assign bus.out_parity = r_par_out;
`else
  logic w_par_unused;
  assign w_par_unused = ^w_par;
`endif

endmodule
